// File: rtl/load_store_unit.sv
// Load/store unit: aligned loads with sign/zero extension, word stores,
// and sub-word stores via read-modify-write against a word-wide data memory.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BIT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0]  req_wdata,
  input  logic                  req_we,
  input  logic                  req_byte,
  input  logic                  req_half,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BIT_WIDTH-1:0]  resp_data,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_readAddr,
  output logic [ADDR_WIDTH-1:0] mem_writeAddr,
  output logic [BIT_WIDTH-1:0]  mem_writeData,
  output logic                  mem_writeEn,
  output logic                  mem_addr_byte,
  output logic                  mem_addr_half,
  input  logic [BIT_WIDTH-1:0]  mem_readData
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BIT_WIDTH-1:0]  wdata_q;
  logic                  byte_q, half_q, unsigned_q;

  logic                  accept;
  logic                  req_is_byte, req_is_half, req_misaligned;
  logic                  is_byte, is_half;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [BIT_WIDTH-1:0]  load_ext, merged;

  // Size decode; both size bits set means word.
  assign req_is_byte    = req_byte & ~req_half;
  assign req_is_half    = req_half & ~req_byte;
  assign req_misaligned = req_is_half ? req_addr[0]
                        : (req_is_byte ? 1'b0 : (req_addr[1:0] != 2'b00));
  assign is_byte        = byte_q & ~half_q;
  assign is_half        = half_q & ~byte_q;
  assign accept         = req_valid && (state_q == IDLE);
  assign word_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_misaligned)                    state_d = RESP;
          else if (!req_we)                      state_d = LOAD;
          else if (!req_is_byte && !req_is_half) state_d = WRITE;
          else                                   state_d = MERGE;
        end
      end
      LOAD:    state_d = RESP;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Extend the right-justified load data from memory.
  always_comb begin
    load_ext = mem_readData;
    if (is_byte)
      load_ext = {{(BIT_WIDTH-BYTE_W){mem_readData[BYTE_W-1] & ~unsigned_q}},
                  mem_readData[BYTE_W-1:0]};
    else if (is_half)
      load_ext = {{(BIT_WIDTH-HALF_W){mem_readData[HALF_W-1] & ~unsigned_q}},
                  mem_readData[HALF_W-1:0]};
  end

  // Splice store data into the word read back from memory.
  always_comb begin
    merged = mem_readData;
    if (is_byte) begin
      unique case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0]  = wdata_q[15:0];
    end
  end

  // Request latch, merged store word and response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      byte_q     <= 1'b0;
      half_q     <= 1'b0;
      unsigned_q <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      byte_q     <= req_byte;
      half_q     <= req_half;
      unsigned_q <= req_unsigned;
      resp_data  <= '0;
      resp_err   <= req_misaligned;
    end else if (state_q == LOAD) begin
      resp_data  <= load_ext;
    end else if (state_q == MERGE) begin
      wdata_q    <= merged;
    end
  end

  // Handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      req_ready  <= (state_d == IDLE);
      resp_valid <= (state_d == RESP);
    end
  end

  // Memory port decode from state and latched request only.
  always_comb begin
    mem_readAddr  = '0;
    mem_writeAddr = '0;
    mem_writeData = '0;
    mem_writeEn   = 1'b0;
    mem_addr_byte = 1'b0;
    mem_addr_half = 1'b0;
    unique case (state_q)
      LOAD: begin
        mem_readAddr  = addr_q;
        mem_addr_byte = is_byte;
        mem_addr_half = is_half;
      end
      MERGE: mem_readAddr = word_addr;
      WRITE: begin
        mem_writeEn   = 1'b1;
        mem_writeAddr = word_addr;
        mem_writeData = wdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide behavioural data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_byte, req_half, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_data;
  logic [31:0] mem_readAddr, mem_writeAddr, mem_writeData, mem_readData;
  logic        mem_writeEn, mem_addr_byte, mem_addr_half;

  logic [31:0] mem [0:1023];
  logic [31:0] rd_word;
  int          write_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  load_store_unit #(.ADDR_WIDTH(32), .BIT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_byte(req_byte),
    .req_half(req_half), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err),
    .mem_readAddr(mem_readAddr), .mem_writeAddr(mem_writeAddr),
    .mem_writeData(mem_writeData), .mem_writeEn(mem_writeEn),
    .mem_addr_byte(mem_addr_byte), .mem_addr_half(mem_addr_half),
    .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  // Combinational memory read: byte/half right-justified, zero-extended.
  assign rd_word = mem[mem_readAddr[11:2]];
  always_comb begin
    mem_readData = rd_word;
    if (mem_addr_byte && !mem_addr_half)
      mem_readData = {24'h0, 8'(rd_word >> (8 * mem_readAddr[1:0]))};
    else if (mem_addr_half && !mem_addr_byte)
      mem_readData = {16'h0, 16'(rd_word >> (16 * mem_readAddr[1]))};
  end

  // Word write port.
  always @(posedge clk) begin
    if (mem_writeEn) begin
      mem[mem_writeAddr[11:2]] <= mem_writeData;
      write_cnt = write_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request and pass the accept edge N (returns at N + 1 time unit).
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic b, input logic h, input logic u);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_byte = b; req_half = h; req_unsigned = u;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL issue_ready: got %b expected 1", req_ready);
    end
    tick();
    req_valid = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_cmp++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL consume: resp_valid=%b req_ready=%b expected 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_writeEn", 32'(mem_writeEn), 32'd0);
    chk("rst_readAddr", mem_readAddr, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic test_load_byte_signed();
    issue(1'b0, 32'h102, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("lb_valid_N1", 32'(resp_valid), 32'd0);
    chk("lb_readAddr", mem_readAddr, 32'h102);
    chk("lb_addr_byte", 32'(mem_addr_byte), 32'd1);
    chk("lb_ready_busy", 32'(req_ready), 32'd0);
    tick();
    chk("lb_valid_N2", 32'(resp_valid), 32'd1);
    chk("lb_data", resp_data, 32'hFFFF_FF99);
    chk("lb_err", 32'(resp_err), 32'd0);
    chk("lb_readAddr_idle", mem_readAddr, 32'h0);
    consume();
  endtask

  task automatic test_load_half();
    issue(1'b0, 32'h102, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("lhu_addr_half", 32'(mem_addr_half), 32'd1);
    tick();
    chk("lhu_valid", 32'(resp_valid), 32'd1);
    chk("lhu_data", resp_data, 32'h0000_8899);
    consume();
    issue(1'b0, 32'h100, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("lh_signed_data", resp_data, 32'hFFFF_AABB);
    consume();
  endtask

  task automatic test_misaligned();
    int wc0;
    wc0 = write_cnt;
    issue(1'b0, 32'h101, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("mis_half_valid_N1", 32'(resp_valid), 32'd1);
    chk("mis_half_err", 32'(resp_err), 32'd1);
    chk("mis_half_data", resp_data, 32'h0);
    consume();
    issue(1'b1, 32'h202, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    chk("mis_word_err", 32'(resp_err), 32'd1);
    chk("mis_word_writeEn", 32'(mem_writeEn), 32'd0);
    consume();
    chk("mis_no_write", 32'(write_cnt), 32'(wc0));
  endtask

  task automatic test_store_byte();
    int wc0;
    wc0 = write_cnt;
    issue(1'b1, 32'h101, 32'h0000_005A, 1'b1, 1'b0, 1'b0);
    chk("sb_merge_readAddr", mem_readAddr, 32'h100);
    chk("sb_merge_byte", 32'(mem_addr_byte), 32'd0);
    chk("sb_merge_writeEn", 32'(mem_writeEn), 32'd0);
    tick();
    chk("sb_writeEn_N2", 32'(mem_writeEn), 32'd1);
    chk("sb_writeData", mem_writeData, 32'h8899_5ABB);
    chk("sb_writeAddr", mem_writeAddr, 32'h100);
    chk("sb_valid_N2", 32'(resp_valid), 32'd0);
    tick();
    chk("sb_valid_N3", 32'(resp_valid), 32'd1);
    chk("sb_writeEn_off", 32'(mem_writeEn), 32'd0);
    chk("sb_resp_data", resp_data, 32'h0);
    chk("sb_one_write", 32'(write_cnt), 32'(wc0 + 1));
    chk("sb_mem", mem[32'h100 >> 2], 32'h8899_5ABB);
    consume();
  endtask

  task automatic test_store_word_stall();
    int wc0;
    wc0 = write_cnt;
    issue(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    chk("sw_writeEn_N1", 32'(mem_writeEn), 32'd1);
    chk("sw_writeAddr", mem_writeAddr, 32'h200);
    chk("sw_writeData", mem_writeData, 32'hDEAD_BEEF);
    tick();
    chk("sw_valid_N2", 32'(resp_valid), 32'd1);
    chk("sw_writeEn_off", 32'(mem_writeEn), 32'd0);
    chk("sw_writeAddr_off", mem_writeAddr, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sw_hold_valid", 32'(resp_valid), 32'd1);
      chk("sw_hold_ready", 32'(req_ready), 32'd0);
      chk("sw_hold_err", 32'(resp_err), 32'd0);
    end
    req_valid = 1'b0;
    chk("sw_one_write", 32'(write_cnt), 32'(wc0 + 1));
    chk("sw_mem", mem[32'h200 >> 2], 32'hDEAD_BEEF);
    consume();
  endtask

  task automatic test_ready_ignored();
    resp_ready = 1'b1;
    issue(1'b0, 32'h200, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("ign_addr_byte", 32'(mem_addr_byte), 32'd0);
    chk("ign_valid_N1", 32'(resp_valid), 32'd0);
    tick();
    chk("ign_valid_N2", 32'(resp_valid), 32'd1);
    chk("ign_data_word", resp_data, 32'hDEAD_BEEF);
    tick();
    resp_ready = 1'b0;
    chk("ign_done", 32'(resp_valid), 32'd0);
    issue(1'b0, 32'h103, 32'h0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("lbu_lane3", resp_data, 32'h0000_0088);
    consume();
  endtask

  task automatic test_reset_abort();
    int wc0;
    wc0 = write_cnt;
    issue(1'b1, 32'h302, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0);
    chk("ab_in_merge", mem_readAddr, 32'h300);
    rst_n = 1'b0;
    #1;
    chk("ab_writeEn", 32'(mem_writeEn), 32'd0);
    chk("ab_resp_valid", 32'(resp_valid), 32'd0);
    tick();
    tick();
    chk("ab_writeEn_hold", 32'(mem_writeEn), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ab_ready", 32'(req_ready), 32'd1);
    chk("ab_valid_after", 32'(resp_valid), 32'd0);
    chk("ab_no_write", 32'(write_cnt), 32'(wc0));
    chk("ab_mem", mem[32'h300 >> 2], 32'h1122_3344);
    issue(1'b1, 32'h302, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0);
    tick();
    chk("sh_hi_writeData", mem_writeData, 32'hBEEF_3344);
    tick();
    consume();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h8899_AABB;
    mem[32'h300 >> 2] = 32'h1122_3344;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_byte = 1'b0; req_half = 1'b0; req_unsigned = 1'b0; resp_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    test_reset();
    test_load_byte_signed();
    test_load_half();
    test_misaligned();
    test_store_byte();
    test_store_word_stall();
    test_ready_ignored();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width shared with data memory.
REQ-002 Parameter BIT_WIDTH, default 32, data word width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  pipeline presents a load/store request.
REQ-006 req_ready  output  1  unit accepts a request this cycle.
REQ-007 req_addr  input  ADDR_WIDTH  byte address.
REQ-008 req_wdata  input  BIT_WIDTH  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 req_byte, req_half  input  1 each  access size; both 0 = word; both 1 is treated as word.
REQ-011 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  consumer accepts response.
REQ-014 resp_data  output  BIT_WIDTH  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  misaligned access, no memory side effect.
REQ-016 mem_readAddr, mem_writeAddr  output  ADDR_WIDTH  to data memory.
REQ-017 mem_writeData  output  BIT_WIDTH; mem_writeEn  output  1; mem_addr_byte, mem_addr_half  output  1.
REQ-018 mem_readData  input  BIT_WIDTH  combinational read data from data memory (byte/half zero-extended, right-justified).

Function
REQ-019 FSM states IDLE, LOAD, MERGE, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 Handshake: request accepted when req_valid && req_ready; all req_* fields latched that edge.
REQ-021 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0; SHALL go IDLE->RESP with resp_err=1, no mem_writeEn.
REQ-022 Aligned load: IDLE->LOAD->RESP; in LOAD drive mem_readAddr=latched addr, mem_addr_byte/half=latched size; capture result into resp_data register.
REQ-023 Load extension: byte sign bit = mem_readData[7], half sign bit = mem_readData[15]; word passes unchanged.
REQ-024 Word store: IDLE->WRITE->RESP; in WRITE mem_writeEn=1, mem_writeAddr=latched addr, mem_writeData=latched wdata.
REQ-025 Sub-word store (read-modify-write): IDLE->MERGE->WRITE->RESP; in MERGE drive mem_readAddr={addr[ADDR_WIDTH-1:2],2'b00}, mem_addr_byte=mem_addr_half=0, and register merged word.
REQ-026 Merge: byte replaces lane addr[1:0] (lane k = bits 8k+7:8k); half replaces [15:0] if addr[1]=0 else [31:16]; other bits from read word.
REQ-027 Latency from accept edge N: error resp_valid at N+1; load and word store at N+2; sub-word store at N+3.
REQ-028 RESP: resp_valid=1 held with stable resp_data/resp_err until resp_ready; on resp_valid && resp_ready return to IDLE next edge; no new accept in that cycle.
REQ-029 mem_writeEn SHALL be 1 only in WRITE, exactly one cycle per store.
REQ-030 Outside LOAD/MERGE, mem_readAddr=0 and mem_addr_byte=mem_addr_half=0; outside WRITE, mem_writeAddr=0, mem_writeData=0.
REQ-031 All mem_* outputs SHALL be combinational decodes of state and latched registers only (no req_* feedthrough).
REQ-032 resp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, clear all latched registers, resp_data=0, resp_err=0, resp_valid=0, mem_writeEn=0, all mem addresses/data 0.
REQ-034 Reset during MERGE or WRITE SHALL abort the store with no memory write after rst_n falls; pending response discarded.
REQ-035 After rst_n rises, req_ready=1 in the first cycle.

Verification
REQ-036 Mem word 0x100 = 0x8899AABB; load byte addr 0x102 signed -> resp_data 0xFFFFFF99 at N+2, resp_err=0.
REQ-037 Same word, load half addr 0x102 unsigned -> resp_data 0x00008899; addr 0x101 half -> resp_err=1 at N+1, resp_data 0.
REQ-038 Store byte 0x5A to 0x101 over 0x8899AABB -> one mem_writeEn pulse at N+2, mem_writeData 0x88995ABB, addr 0x100; resp_valid at N+3.
REQ-039 Store word 0xDEADBEEF to 0x200 -> mem_writeEn at N+1 only, resp_valid N+2; hold resp_ready=0 five cycles -> resp_valid, req_ready=0 stable throughout.
REQ-040 Store half to 0x302, assert rst_n=0 in MERGE cycle -> no mem_writeEn, resp_valid=0, word 0x300 unchanged, req_ready=1 after release.
